// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Fetch-time conditional branch predictor built on a PC-indexed table of
//   2-bit saturating counters. Each prediction travels with its instruction
//   through a two-entry tracking pipe (F->D, D->EX). In EX it is compared
//   with the resolved outcome to raise the redirect and train the table.
//
//   Optional build macro: BP_STATS_EN
//     Adds the stat_branches / stat_mispredicts counter outputs.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int WIDTH       = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             f_valid,
    input  logic             f_is_branch,
    input  logic [WIDTH-1:0] f_pc,
    input  logic [WIDTH-1:0] f_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    output logic             branch_en_F,
    output logic             branch_en_EX,
    output logic             branch_correction,
    output logic [WIDTH-1:0] branch_addr,
    output logic             flush
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    // One in-flight prediction record.
    typedef struct packed {
        logic             valid;
        logic             pred_taken;
        logic [IDX_W-1:0] idx;
    } trk_entry_t;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_MAX     = 2'b11;
    localparam logic [1:0] CNT_MIN     = 2'b00;

    logic [1:0]       r_bht [BHT_ENTRIES];
    trk_entry_t       r_trk_d;
    trk_entry_t       r_trk_ex;

    logic [IDX_W-1:0] w_f_idx;
    logic             w_pred_f;
    logic             w_resolve;
    logic             w_mispredict;
    logic [1:0]       w_train_cur;
    logic [1:0]       w_train_next;
    logic             w_unused_pc;

    // The table index drops the two byte-offset bits; the rest of the PCs is
    // unused (fall-through is handled outside by the PC mux).
    assign w_f_idx     = f_pc[IDX_W+1:2];
    assign w_unused_pc = ^{ex_pc, f_pc[WIDTH-1:IDX_W+2], f_pc[1:0]};

    // Fetch prediction reads the pre-update counter value.
    assign w_pred_f     = f_valid & f_is_branch & r_bht[w_f_idx][1];
    assign w_resolve    = ex_valid & ex_is_branch & r_trk_ex.valid;
    assign w_mispredict = w_resolve & (ex_taken != r_trk_ex.pred_taken);

    // Saturating next value for the counter being trained this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_train_cur  = r_bht[r_trk_ex.idx];
        w_train_next = w_train_cur;
        if (ex_taken) begin
            if (w_train_cur != CNT_MAX) w_train_next = w_train_cur + 2'd1;
        end else begin
            if (w_train_cur != CNT_MIN) w_train_next = w_train_cur - 2'd1;
        end
    end

    // Counter table: reset to weakly-not-taken, trained when EX resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the table is reset entry by entry because every counter must
        // start weakly-not-taken, so it is built from flops, not a RAM macro.
        // Non-blocking assignments keep all state updates on the same edge.
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_WEAK_NT;
        end else if (w_resolve) begin
            r_bht[r_trk_ex.idx] <= w_train_next;
        end
    end

    // Tracking pipe: flush clears both entries, stall holds, otherwise shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk_d  <= '0;
            r_trk_ex <= '0;
        end else if (w_mispredict) begin
            r_trk_d.valid  <= 1'b0;
            r_trk_ex.valid <= 1'b0;
        end else if (!stall) begin
            r_trk_ex           <= r_trk_d;
            r_trk_d.valid      <= f_valid & f_is_branch;
            r_trk_d.pred_taken <= w_pred_f;
            r_trk_d.idx        <= w_f_idx;
        end
    end

    // PC-mux steering; the EX redirect wins over the fetch prediction and
    // everything is held low while reset is asserted.
    always_comb begin
        branch_en_F       = 1'b0;
        branch_en_EX      = 1'b0;
        branch_correction = 1'b0;
        branch_addr       = '0;
        flush             = 1'b0;
        if (rst_n) begin
            branch_en_EX      = w_mispredict;
            branch_correction = w_mispredict & r_trk_ex.pred_taken;
            flush             = w_mispredict;
            branch_en_F       = w_pred_f & ~w_mispredict;
            branch_addr       = w_mispredict ? ex_target : f_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Resolved-branch and misprediction counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_resolve)    r_stat_branches    <= r_stat_branches + 32'd1;
            if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural predictor model (integer counter array + queue of in-flight
//   predictions). Inputs change on the falling edge; outputs are sampled 2ns
//   later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int W       = 32;
    localparam int ENTRIES = 64;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          f_valid;
    logic          f_is_branch;
    logic [W-1:0]  f_pc;
    logic [W-1:0]  f_target;
    logic          ex_valid;
    logic          ex_is_branch;
    logic          ex_taken;
    logic [W-1:0]  ex_pc;
    logic [W-1:0]  ex_target;
    logic          branch_en_F;
    logic          branch_en_EX;
    logic          branch_correction;
    logic [W-1:0]  branch_addr;
    logic          flush;
`ifdef BP_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;
`endif

    branch_predict_unit #(.WIDTH(W), .BHT_ENTRIES(ENTRIES)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .f_valid           (f_valid),
        .f_is_branch       (f_is_branch),
        .f_pc              (f_pc),
        .f_target          (f_target),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_taken          (ex_taken),
        .ex_pc             (ex_pc),
        .ex_target         (ex_target),
        .branch_en_F       (branch_en_F),
        .branch_en_EX      (branch_en_EX),
        .branch_correction (branch_correction),
        .branch_addr       (branch_addr),
        .flush             (flush)
`ifdef BP_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Counters held as plain integers 0..3; in-flight predictions as a queue
    // whose front is the youngest (decode) and back is the one in EX.
    typedef struct {
        bit v;
        bit p;
        int idx;
    } trk_t;

    int          bht_m [ENTRIES];
    trk_t        pipe_q [$];
    logic [31:0] m_branches;
    logic [31:0] m_mispredicts;

    bit          e_pred_f, e_resolve, e_misp;
    bit          e_en_f, e_en_ex, e_corr;
    logic [31:0] e_addr;
    int          e_idx;

    task automatic model_reset();
        trk_t t;
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
        t.v = 0; t.p = 0; t.idx = 0;
        pipe_q = {};
        pipe_q.push_back(t);
        pipe_q.push_back(t);
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    task automatic model_eval();
        trk_t ex_e;
        ex_e      = pipe_q[1];
        e_idx     = int'((f_pc / 4) % ENTRIES);
        e_pred_f  = f_valid && f_is_branch && (bht_m[e_idx] >= 2);
        e_resolve = ex_valid && ex_is_branch && ex_e.v;
        e_misp    = e_resolve && (ex_taken != ex_e.p);
        e_en_ex   = e_misp;
        e_corr    = e_misp && ex_e.p;
        e_en_f    = e_pred_f && !e_misp;
        e_addr    = e_misp ? ex_target : f_target;
    endtask

    task automatic model_advance();
        trk_t ex_e, t;
        model_eval();
        ex_e = pipe_q[1];
        if (e_resolve) begin
            if (ex_taken) bht_m[ex_e.idx] = (bht_m[ex_e.idx] == 3) ? 3 : bht_m[ex_e.idx] + 1;
            else          bht_m[ex_e.idx] = (bht_m[ex_e.idx] == 0) ? 0 : bht_m[ex_e.idx] - 1;
            m_branches = m_branches + 1;
        end
        if (e_misp) m_mispredicts = m_mispredicts + 1;
        if (e_misp) begin
            for (int i = 0; i < 2; i++) begin
                t = pipe_q[i]; t.v = 0; pipe_q[i] = t;
            end
        end else if (!stall) begin
            t.v = f_valid && f_is_branch; t.p = e_pred_f; t.idx = e_idx;
            pipe_q.push_front(t);
            void'(pipe_q.pop_back());
        end
    endtask

    task automatic check_model(input string tag);
        model_eval();
        check({tag, ".en_F"},   {31'd0, branch_en_F},       {31'd0, e_en_f});
        check({tag, ".en_EX"},  {31'd0, branch_en_EX},      {31'd0, e_en_ex});
        check({tag, ".corr"},   {31'd0, branch_correction}, {31'd0, e_corr});
        check({tag, ".addr"},   branch_addr,                e_addr);
        check({tag, ".flush"},  {31'd0, flush},             {31'd0, e_en_ex});
`ifdef BP_STATS_EN
        check({tag, ".st_br"},  stat_branches,    m_branches);
        check({tag, ".st_mis"}, stat_mispredicts, m_mispredicts);
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge: apply inputs, settle, compare.
    task automatic step(input string tag, input logic st, input logic fv, input logic fb,
                        input logic [31:0] pc, input logic [31:0] ft,
                        input logic ev, input logic eb, input logic et,
                        input logic [31:0] etgt);
        stall        = st;
        f_valid      = fv;
        f_is_branch  = fb;
        f_pc         = pc;
        f_target     = ft;
        ex_valid     = ev;
        ex_is_branch = eb;
        ex_taken     = et;
        ex_target    = etgt;
        ex_pc        = etgt ^ 32'h0000_0ff0;
        #2;
        check_model(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    // Assert reset asynchronously mid-cycle, check outputs drop at once.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".en_F"},  {31'd0, branch_en_F},       32'd0);
        check({tag, ".en_EX"}, {31'd0, branch_en_EX},      32'd0);
        check({tag, ".corr"},  {31'd0, branch_correction}, 32'd0);
        check({tag, ".addr"},  branch_addr,                32'd0);
        check({tag, ".flush"}, {31'd0, flush},             32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        stall = 0; f_valid = 0; f_is_branch = 0; f_pc = 0; f_target = 0;
        ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pc = 0; ex_target = 0;
        model_reset();

        // Reset state: outputs low even with an active fetch on the inputs.
        @(negedge clk);
        f_valid = 1; f_is_branch = 1; f_pc = 32'h100; f_target = 32'h1234;
        #2;
        check("rst.en_F", {31'd0, branch_en_F}, 32'd0);
        check("rst.addr", branch_addr, 32'd0);
        check("rst.flush", {31'd0, flush}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold branch predicts not taken, resolves taken -> redirect.
        step("t1a", 0, 1, 1, 32'h100, 32'h80, 0, 0, 0, 32'h0);
        check("t1a.nt", {31'd0, branch_en_F}, 32'd0);
        tick();
        step("t1b", 0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0);
        tick();
        step("t1c", 0, 1, 0, 32'h108, 32'h10c, 1, 1, 1, 32'h80);
        check("t1c.en_EX", {31'd0, branch_en_EX}, 32'd1);
        check("t1c.corr", {31'd0, branch_correction}, 32'd0);
        check("t1c.addr", branch_addr, 32'h80);
        check("t1c.flush", {31'd0, flush}, 32'd1);
        tick();

        // 2: counter now 10 -> predict taken; train to 11 and saturate.
        step("t2a", 0, 1, 1, 32'h100, 32'h80, 0, 0, 0, 32'h0);
        check("t2a.en_F", {31'd0, branch_en_F}, 32'd1);
        check("t2a.addr", branch_addr, 32'h80);
        tick();
        step("t2b", 0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0);
        tick();
        step("t2c", 0, 1, 1, 32'h100, 32'h80, 1, 1, 1, 32'h80);
        check("t2c.no_redir", {31'd0, branch_en_EX}, 32'd0);
        check("t2c.en_F", {31'd0, branch_en_F}, 32'd1);
        tick();
        step("t2d", 0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0);
        tick();
        step("t2e", 0, 1, 1, 32'h100, 32'h80, 1, 1, 1, 32'h80);
        check("t2e.no_redir", {31'd0, branch_en_EX}, 32'd0);
        tick();
        step("t3a", 0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0);
        tick();

        // 3+4: from 11 resolve not taken while fetch also predicts taken.
        step("t3b", 0, 1, 1, 32'h100, 32'h80, 1, 1, 0, 32'h104);
        check("t3b.en_EX", {31'd0, branch_en_EX}, 32'd1);
        check("t3b.corr", {31'd0, branch_correction}, 32'd1);
        check("t3b.en_F", {31'd0, branch_en_F}, 32'd0);
        check("t3b.addr", branch_addr, 32'h104);
        check("t3b.flush", {31'd0, flush}, 32'd1);
        tick();
        step("t4b", 0, 1, 1, 32'h100, 32'h80, 1, 1, 0, 32'h104);
        check("t4b.still_T", {31'd0, branch_en_F}, 32'd1);
        check("t4b.ex_inv", {31'd0, branch_en_EX}, 32'd0);
        tick();
        step("t4c", 0, 1, 0, 32'h104, 32'h0, 1, 1, 0, 32'h104);
        check("t4c.d_inv", {31'd0, branch_en_EX}, 32'd0);
        tick();
        step("t4d", 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h80);
        tick();

        // 5: a branch in D survives a 3-cycle stall with its prediction.
        step("t5a", 0, 1, 1, 32'h204, 32'h400, 0, 0, 0, 32'h0);
        check("t5a.nt", {31'd0, branch_en_F}, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            step("t5s", 1, 1, 0, 32'h208, 32'h0, 0, 0, 0, 32'h0);
            tick();
        end
        step("t5e", 0, 1, 0, 32'h208, 32'h0, 0, 0, 0, 32'h0);
        tick();
        step("t5f", 0, 1, 0, 32'h20c, 32'h0, 1, 1, 1, 32'h400);
        check("t5f.en_EX", {31'd0, branch_en_EX}, 32'd1);
        check("t5f.corr", {31'd0, branch_correction}, 32'd0);
        check("t5f.addr", branch_addr, 32'h400);
        tick();

        // 6: train 0x308 to 11, reset mid-cycle, counter back to 01.
        for (int k = 0; k < 2; k++) begin
            step("t6f", 0, 1, 1, 32'h308, 32'h500, 0, 0, 0, 32'h0);
            tick();
            step("t6n", 0, 1, 0, 32'h30c, 32'h0, 0, 0, 0, 32'h0);
            tick();
            step("t6r", 0, 1, 0, 32'h310, 32'h0, 1, 1, 1, 32'h500);
            tick();
        end
        step("t6", 0, 1, 1, 32'h308, 32'h500, 0, 0, 0, 32'h0);
        check("t6.trained", {31'd0, branch_en_F}, 32'd1);
        apply_reset("t6rst");
        step("t6post", 0, 1, 1, 32'h308, 32'h500, 0, 0, 0, 32'h0);
        check("t6post.nt", {31'd0, branch_en_F}, 32'd0);
        tick();

        // Randomized traffic with aliasing PCs, stalls and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            step("rnd",
                 logic'($urandom_range(0, 4) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) != 0),
                 (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8),
                 $urandom,
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 $urandom);
            if ($urandom_range(0, 299) == 0) apply_reset("rnd_rst");
            else                             tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
